// File: rtl/canny_pkg.sv
// Shared types and helpers for the Canny output streaming stage and its raster counter.
package canny_pkg;

  typedef logic [7:0] pix_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

  // Counter width for a dimension; a dimension of 1 still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Row/column raster position counter with frame-boundary flags.
module raster_counter
  import canny_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  localparam int CW = cnt_width(FRAME_WIDTH),
  localparam int RW = cnt_width(FRAME_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          sol,
  output logic          eol,
  output logic          sof,
  output logic          eof,
  output logic          last
);

  localparam logic [CW-1:0] LAST_COL = CW'(FRAME_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(FRAME_HEIGHT - 1);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (adv) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign row  = r_row;
  assign col  = r_col;
  assign sol  = (r_col == '0);
  assign eol  = (r_col == LAST_COL);
  assign sof  = (r_row == '0) && (r_col == '0);
  assign eof  = (r_row == LAST_ROW) && (r_col == LAST_COL);
  assign last = eof;

endmodule

// File: rtl/canny_stream_out.sv
// Serializes a completed Canny edge frame into a ready/valid pixel stream with overrun detection.
// Optional per-frame nonzero-pixel count enabled by defining CANNY_EDGE_COUNT_EN.
module canny_stream_out
  import canny_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int PIX_WIDTH    = 24,
  localparam int PW  = PIX_WIDTH / 3,
  localparam int CW  = cnt_width(FRAME_WIDTH),
  localparam int RW  = cnt_width(FRAME_HEIGHT),
  localparam int ECW = $clog2(FRAME_WIDTH * FRAME_HEIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          canny_val,
  input  logic [PW-1:0] canny_data [FRAME_HEIGHT][FRAME_WIDTH],
  input  logic          out_ready,
  output logic          out_val,
  output logic          out_sof,
  output logic          out_eof,
  output logic          out_sol,
  output logic          out_eol,
  output logic [PW-1:0] out_data,
`ifdef CANNY_EDGE_COUNT_EN
  output logic [ECW-1:0] edge_cnt,
  output logic           edge_cnt_val,
`endif
  output logic          busy,
  output logic          frame_drop
);

  // state  | meaning
  // IDLE   | no frame in flight, waiting for canny_val
  // STREAM | presenting the beat at (row, col), advancing on accept

  stream_state_t r_state, w_state_nxt;
  logic          r_drop, w_drop_nxt;
  logic          w_clr, w_adv, w_accept, w_active;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic          w_sol, w_eol, w_sof, w_eof, w_last;
  logic [PW-1:0] w_pix;

  raster_counter #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .FRAME_HEIGHT(FRAME_HEIGHT)
  ) u_raster (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_clr),
    .adv  (w_adv),
    .row  (w_row),
    .col  (w_col),
    .sol  (w_sol),
    .eol  (w_eol),
    .sof  (w_sof),
    .eof  (w_eof),
    .last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  assign w_active = (r_state == STREAM);
  assign w_accept = w_active && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_adv       = 1'b0;
    w_drop_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (canny_val) begin
          w_state_nxt = STREAM;
          w_clr       = 1'b1;
        end
      end
      STREAM: begin
        if (w_accept) begin
          w_adv = 1'b1;
          // The counter wraps to (0,0) after eof, so a coincident canny_val restarts seamlessly.
          if (w_last && !canny_val) begin
            w_state_nxt = IDLE;
            w_clr       = 1'b1;
          end
        end
        if (canny_val && !(w_accept && w_last)) w_drop_nxt = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_pix      = canny_data[w_row][w_col];
  assign out_val    = w_active;
  assign out_sof    = w_active && w_sof;
  assign out_eof    = w_active && w_eof;
  assign out_sol    = w_active && w_sol;
  assign out_eol    = w_active && w_eol;
  assign out_data   = w_active ? w_pix : '0;
  assign busy       = w_active;
  assign frame_drop = r_drop;

`ifdef CANNY_EDGE_COUNT_EN
  logic [ECW-1:0] r_edge_cnt;
  logic           r_edge_val;
  logic [ECW-1:0] w_hit;

  assign w_hit = ECW'(w_pix != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge_cnt <= '0;
      r_edge_val <= 1'b0;
    end else begin
      r_edge_val <= w_accept && w_eof;
      if (w_accept) r_edge_cnt <= w_sof ? w_hit : r_edge_cnt + w_hit;
    end
  end

  assign edge_cnt     = r_edge_cnt;
  assign edge_cnt_val = r_edge_val;
`endif

endmodule

// File: tb/tb_canny_stream_out.sv
// Directed testbench for canny_stream_out: 4x3 frame plus a 1x1 frame instance.
module tb_canny_stream_out;

  localparam int W = 4;
  localparam int H = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // 4x3 instance
  logic       canny_val = 1'b0;
  logic [7:0] frame [H][W];
  logic       out_ready = 1'b1;
  logic       out_val, out_sof, out_eof, out_sol, out_eol, busy, frame_drop;
  logic [7:0] out_data;
`ifdef CANNY_EDGE_COUNT_EN
  logic [3:0] edge_cnt;
  logic       edge_cnt_val;
`endif

  canny_stream_out #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .PIX_WIDTH(24)) dut (
    .clk(clk), .rst_n(rst_n), .canny_val(canny_val), .canny_data(frame),
    .out_ready(out_ready), .out_val(out_val), .out_sof(out_sof), .out_eof(out_eof),
    .out_sol(out_sol), .out_eol(out_eol), .out_data(out_data),
`ifdef CANNY_EDGE_COUNT_EN
    .edge_cnt(edge_cnt), .edge_cnt_val(edge_cnt_val),
`endif
    .busy(busy), .frame_drop(frame_drop)
  );

  // 1x1 instance
  logic       canny_val1 = 1'b0;
  logic [7:0] frame1 [1][1];
  logic       out_val1, out_sof1, out_eof1, out_sol1, out_eol1, busy1, frame_drop1;
  logic [7:0] out_data1;
`ifdef CANNY_EDGE_COUNT_EN
  logic [0:0] edge_cnt1;
  logic       edge_cnt_val1;
`endif

  canny_stream_out #(.FRAME_WIDTH(1), .FRAME_HEIGHT(1), .PIX_WIDTH(24)) dut1 (
    .clk(clk), .rst_n(rst_n), .canny_val(canny_val1), .canny_data(frame1),
    .out_ready(1'b1), .out_val(out_val1), .out_sof(out_sof1), .out_eof(out_eof1),
    .out_sol(out_sol1), .out_eol(out_eol1), .out_data(out_data1),
`ifdef CANNY_EDGE_COUNT_EN
    .edge_cnt(edge_cnt1), .edge_cnt_val(edge_cnt_val1),
`endif
    .busy(busy1), .frame_drop(frame_drop1)
  );

  // {busy, val, sof, eof, sol, eol, data}
  function automatic logic [13:0] exp_beat(input int idx);
    int r, c;
    r = idx / W;
    c = idx % W;
    return {1'b1, 1'b1, 1'(idx == 0), 1'(idx == W*H-1), 1'(c == 0), 1'(c == W-1),
            8'(16*r + c)};
  endfunction

  function automatic logic [13:0] obs;
    return {busy, out_val, out_sof, out_eof, out_sol, out_eol, out_data};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame;
    canny_val = 1'b1;
    tick();
    canny_val = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_total++;
    if (obs() !== 14'h0 || frame_drop !== 1'b0)
      $display("FAIL reset_outputs: got %h drop %b, want 0000 drop 0", obs(), frame_drop);
    else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_total++;
    if (obs() !== 14'h0) $display("FAIL reset_idle: got %h, want 0000", obs());
    else n_pass++;
  endtask

  task automatic test_stream;
    out_ready = 1'b1;
    start_frame();
    for (int i = 0; i < W*H; i++) begin
      n_total++;
      if (obs() !== exp_beat(i))
        $display("FAIL stream_beat%0d: got %h, want %h", i, obs(), exp_beat(i));
      else n_pass++;
      tick();
    end
    n_total++;
    if (obs() !== 14'h0) $display("FAIL stream_end: got %h, want 0000", obs());
    else n_pass++;
`ifdef CANNY_EDGE_COUNT_EN
    n_total++;
    if (edge_cnt !== 4'd11 || edge_cnt_val !== 1'b1)
      $display("FAIL edge_cnt_4x3: got %0d val %b, want 11 val 1", edge_cnt, edge_cnt_val);
    else n_pass++;
    tick();
    n_total++;
    if (edge_cnt_val !== 1'b0) $display("FAIL edge_val_pulse: got %b, want 0", edge_cnt_val);
    else n_pass++;
`endif
  endtask

  task automatic test_stall;
    logic [3:0] pat;
    int idx, cyc;
    pat = 4'b1001;
    idx = 0;
    cyc = 0;
    start_frame();
    while (idx < W*H && cyc < 80) begin
      out_ready = pat[cyc % 4];
      n_total++;
      if (obs() !== exp_beat(idx))
        $display("FAIL stall_cyc%0d: got %h, want beat %0d %h", cyc, obs(), idx, exp_beat(idx));
      else n_pass++;
      if (out_ready) idx++;
      cyc++;
      tick();
    end
    out_ready = 1'b1;
    n_total++;
    if (idx != W*H || obs() !== 14'h0)
      $display("FAIL stall_end: got beats %0d out %h, want 12 out 0000", idx, obs());
    else n_pass++;
  endtask

  task automatic test_drop;
    out_ready = 1'b1;
    start_frame();
    for (int i = 0; i < W*H; i++) begin
      n_total++;
      if (obs() !== exp_beat(i) || frame_drop !== 1'(i == 6))
        $display("FAIL drop_beat%0d: got %h drop %b, want %h drop %b",
                 i, obs(), frame_drop, exp_beat(i), 1'(i == 6));
      else n_pass++;
      canny_val = (i == 5);
      tick();
    end
    canny_val = 1'b0;
    n_total++;
    if (obs() !== 14'h0 || frame_drop !== 1'b0)
      $display("FAIL drop_end: got %h drop %b, want 0000 drop 0", obs(), frame_drop);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    start_frame();
    for (int i = 0; i < W*H; i++) begin
      canny_val = (i == W*H-1);
      tick();
    end
    canny_val = 1'b0;
    for (int i = 0; i < W*H; i++) begin
      n_total++;
      if (obs() !== exp_beat(i) || frame_drop !== 1'b0)
        $display("FAIL b2b_beat%0d: got %h drop %b, want %h drop 0",
                 i, obs(), frame_drop, exp_beat(i));
      else n_pass++;
      tick();
    end
    n_total++;
    if (obs() !== 14'h0) $display("FAIL b2b_end: got %h, want 0000", obs());
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    out_ready = 1'b1;
    start_frame();
    for (int i = 0; i < 6; i++) tick();
    n_total++;
    if (obs() !== exp_beat(6)) $display("FAIL mreset_pre: got %h, want %h", obs(), exp_beat(6));
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (obs() !== 14'h0 || frame_drop !== 1'b0)
      $display("FAIL mreset_async: got %h drop %b, want 0000 drop 0", obs(), frame_drop);
    else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    n_total++;
    if (obs() !== 14'h0) $display("FAIL mreset_idle: got %h, want 0000", obs());
    else n_pass++;
    start_frame();
    n_total++;
    if (obs() !== exp_beat(0)) $display("FAIL mreset_restart: got %h, want %h", obs(), exp_beat(0));
    else n_pass++;
    for (int i = 0; i < W*H; i++) tick();
  endtask

  task automatic test_single_pixel;
    logic [13:0] o1;
    canny_val1 = 1'b1;
    tick();
    canny_val1 = 1'b0;
    o1 = {busy1, out_val1, out_sof1, out_eof1, out_sol1, out_eol1, out_data1};
    n_total++;
    if (o1 !== {6'b111111, 8'h7F}) $display("FAIL one_px_beat: got %h, want 3f7f", o1);
    else n_pass++;
    tick();
    o1 = {busy1, out_val1, out_sof1, out_eof1, out_sol1, out_eol1, out_data1};
    n_total++;
    if (o1 !== 14'h0) $display("FAIL one_px_end: got %h, want 0000", o1);
    else n_pass++;
`ifdef CANNY_EDGE_COUNT_EN
    n_total++;
    if (edge_cnt1 !== 1'b1 || edge_cnt_val1 !== 1'b1)
      $display("FAIL one_px_edge: got %0d val %b, want 1 val 1", edge_cnt1, edge_cnt_val1);
    else n_pass++;
`endif
  endtask

  initial begin
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        frame[r][c] = 8'(16*r + c);
    frame1[0][0] = 8'h7F;
    test_reset();
    test_stream();
    test_stall();
    test_drop();
    test_back_to_back();
    test_mid_reset();
    test_single_pixel();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
